// File: rtl/ti_share_compress_gf4.sv
// Two-stage share compressor: four GF(2^4) product shares in, two remasked shares out.
// S1 is a pure latch of the inputs so no share recombination happens before a register.
module ti_share_compress_gf4 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             ClkxCI,
    input  logic             RstxBI,
    input  logic [3:0]       QxDI0,
    input  logic [3:0]       QxDI1,
    input  logic [3:0]       QxDI2,
    input  logic [3:0]       QxDI3,
    input  logic [3:0]       MaskxDI,
    input  logic             InValidxSI,
    output logic             InReadyxSO,
    output logic [3:0]       ZxDO0,
    output logic [3:0]       ZxDO1,
    output logic             OutValidxSO,
    input  logic             OutReadyxSI,
    output logic [CNT_W-1:0] BeatCntxDO
);

    logic [3:0]       q0_q, q1_q, q2_q, q3_q, m_q;
    logic             v1_q;
    logic [3:0]       z0_q, z1_q;
    logic             v2_q;
    logic [CNT_W-1:0] cnt_q;

    logic             adv2;
    logic             in_ready;
    logic             fire_in;
    logic [3:0]       z0_d, z1_d;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // Ready is combinational from OutReadyxSI so a full pipe can shift in one cycle.
    always_comb begin
        adv2     = ~v2_q | OutReadyxSI;
        in_ready = ~v1_q | adv2;
        fire_in  = InValidxSI & in_ready;
        z0_d     = q0_q ^ q1_q ^ m_q;
        z1_d     = q2_q ^ q3_q ^ m_q;
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            v1_q <= 1'b0;
            q0_q <= 4'h0;
            q1_q <= 4'h0;
            q2_q <= 4'h0;
            q3_q <= 4'h0;
            m_q  <= 4'h0;
        end else if (in_ready) begin
            v1_q <= InValidxSI;
            if (InValidxSI) begin
                q0_q <= QxDI0;
                q1_q <= QxDI1;
                q2_q <= QxDI2;
                q3_q <= QxDI3;
                m_q  <= MaskxDI;
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            v2_q <= 1'b0;
            z0_q <= 4'h0;
            z1_q <= 4'h0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                z0_q <= z0_d;
                z1_q <= z1_d;
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            cnt_q <= '0;
        end else if (fire_in) begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    assign InReadyxSO  = in_ready;
    assign ZxDO0       = z0_q;
    assign ZxDO1       = z1_q;
    assign OutValidxSO = v2_q;
    assign BeatCntxDO  = cnt_q;

endmodule

// File: tb/tb_ti_share_compress_gf4.sv
// Bench for ti_share_compress_gf4: a queue of in-flight beats models the stage; directed
// scenarios plus a randomized handshake run are checked against it every cycle.
module tb_ti_share_compress_gf4;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       q0, q1, q2, q3, mask;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       z0, z1;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] beat_cnt;

    ti_share_compress_gf4 #(.CNT_W(CNT_W)) dut (
        .ClkxCI     (clk),
        .RstxBI     (rst_n),
        .QxDI0      (q0),
        .QxDI1      (q1),
        .QxDI2      (q2),
        .QxDI3      (q3),
        .MaskxDI    (mask),
        .InValidxSI (in_valid),
        .InReadyxSO (in_ready),
        .ZxDO0      (z0),
        .ZxDO1      (z1),
        .OutValidxSO(out_valid),
        .OutReadyxSI(out_ready),
        .BeatCntxDO (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] z0;
        logic [3:0] z1;
        logic [3:0] x;
        int         acc;
    } beat_t;

    beat_t mq[$];
    int    cyc;
    int    cnt_m;
    int    errors;
    int    checks;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: inputs already driven after a negedge; check, advance model, wait next negedge.
    task automatic step(output logic accepted);
        logic  exp_ready, exp_ov, fire_out, fire_in;
        beat_t b;
        #1;
        exp_ready = (mq.size() < 2) || out_ready;
        exp_ov    = (mq.size() > 0) && (cyc - mq[0].acc >= 1);
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("out_valid", out_valid, exp_ov);
        check_eq("beat_cnt", beat_cnt, cnt_m);
        if (exp_ov) begin
            check_eq("z0", z0, mq[0].z0);
            check_eq("z1", z1, mq[0].z1);
            check_eq("z_xor", z0 ^ z1, mq[0].x);
        end
        fire_out = exp_ov && out_ready;
        fire_in  = in_valid && exp_ready;
        cyc++;
        if (fire_out) void'(mq.pop_front());
        if (fire_in) begin
            b.z0  = q0 ^ q1 ^ mask;
            b.z1  = q2 ^ q3 ^ mask;
            b.x   = q0 ^ q1 ^ q2 ^ q3;
            b.acc = cyc;
            mq.push_back(b);
            cnt_m = (cnt_m + 1) % (1 << CNT_W);
        end
        accepted = fire_in;
        @(negedge clk);
    endtask

    task automatic run_beat(input logic [3:0] a, b, c, d, mm);
        logic acc;
        int   n;
        q0 = a; q1 = b; q2 = c; q3 = d; mask = mm;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: got no transfer expected one within 20 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic rand_beat();
        run_beat(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic async_reset_check();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_z0", z0, 4'h0);
        check_eq("rst_z1", z1, 4'h0);
        check_eq("rst_beat_cnt", beat_cnt, 0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        mq.delete();
        cnt_m = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        errors = 0; checks = 0; cyc = 0; cnt_m = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        q0 = 4'h0; q1 = 4'h0; q2 = 4'h0; q3 = 4'h0; mask = 4'h0;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_z0", z0, 4'h0);
        check_eq("rst_z1", z1, 4'h0);
        check_eq("rst_beat_cnt", beat_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single known beat: Z0 = 1^2^5 = 6, Z1 = 4^8^5 = 9.
        out_ready = 1'b1;
        run_beat(4'h1, 4'h2, 4'h4, 4'h8, 4'h5);
        #1;
        check_eq("single_ov_early", out_valid, 1'b0);
        check_eq("single_cnt", beat_cnt, 1);
        @(negedge clk);
        #1;
        check_eq("single_ov", out_valid, 1'b1);
        check_eq("single_z0", z0, 4'h6);
        check_eq("single_z1", z1, 4'h9);
        @(negedge clk);
        #1;
        check_eq("single_ov_drop", out_valid, 1'b0);
        cyc += 2;
        mq.delete();
        @(negedge clk);

        // Streaming, 16 back-to-back beats; 1 + 16 = 17 beats takes the 4-bit counter through wrap.
        for (int i = 0; i < 16; i++) rand_beat();
        idle(3);
        check_eq("stream_cnt", beat_cnt, 17 % 16);

        // Backpressure: A, then B with ready low, C stalls 5 cycles before release.
        rand_beat();
        out_ready = 1'b0;
        rand_beat();
        q0 = 4'hc; q1 = 4'h3; q2 = 4'ha; q3 = 4'h6; mask = 4'h9;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step(acc);
        out_ready = 1'b1;
        run_beat(4'hc, 4'h3, 4'ha, 4'h6, 4'h9);
        idle(4);

        // Bubbles: valid pattern 1,0,1,0.
        for (int i = 0; i < 2; i++) begin
            rand_beat();
            idle(1);
        end
        idle(3);

        // Mid-operation reset with both stages full and downstream stalled.
        rand_beat();
        out_ready = 1'b0;
        rand_beat();
        idle(2);
        async_reset_check();
        out_ready = 1'b1;
        run_beat(4'h7, 4'h0, 4'hf, 4'h2, 4'h3);
        idle(3);

        // Randomized handshake with held-until-accepted sources.
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                q0 = 4'($urandom); q1 = 4'($urandom); q2 = 4'($urandom); q3 = 4'($urandom);
                mask = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        out_ready = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ti_share_compress_gf4.md
# ti_share_compress_gf4

Registered share-compression stage for the 4-share GF(2^4) multiplier outputs of the TI AES S-box datapath. It accepts four product shares per beat under a valid/ready handshake. It latches them behind a glitch-isolating register stage, then remasks and compresses them into two output shares. The resulting pair feeds the 2-share inversion/affine stages. It is the consumer end of the 4-share multiplier interface, and restores the share count the S-box expects downstream.

## Interface
- CNT_W, 8, width of the accepted-beat counter
- ClkxCI  input  1  clock, all state on rising edge
- RstxBI  input  1  asynchronous active-low reset
- QxDI0  input  4  product share 0
- QxDI1  input  4  product share 1
- QxDI2  input  4  product share 2
- QxDI3  input  4  product share 3
- MaskxDI  input  4  fresh random mask, one per accepted beat
- InValidxSI  input  1  shares and mask valid
- InReadyxSO  output  1  stage can accept this cycle
- ZxDO0  output  4  compressed share 0
- ZxDO1  output  4  compressed share 1
- OutValidxSO  output  1  ZxDO0/ZxDO1 valid
- OutReadyxSI  input  1  downstream accepts
- BeatCntxDO  output  CNT_W  number of beats accepted since reset, wrapping

## Operation
- Clocking is single-clock (ClkxCI). Reset RstxBI is asynchronous and active-low.
- Stage 1 register S1 holds Q0..Q3 and Mask, plus valid bit V1. No XOR is permitted between the inputs and S1, so shares stay non-complete up to the register.
- Stage 2 register S2 holds Z0 = S1.Q0 ^ S1.Q1 ^ S1.M and Z1 = S1.Q2 ^ S1.Q3 ^ S1.M, plus valid bit V2. The Z0/Z1 logic reads only S1 outputs.
- The design invariant is ZxDO0 ^ ZxDO1 = Q0 ^ Q1 ^ Q2 ^ Q3 of the corresponding accepted beat.
- Handshake:
  - Transfer in: InValidxSI & InReadyxSO at a rising edge.
  - Transfer out: OutValidxSO & OutReadyxSI at a rising edge.
  - Source must hold data, mask and valid stable until the transfer in occurs.
- Ready chain:
  - Adv2 = ~V2 | OutReadyxSI
  - InReadyxSO = ~V1 | Adv2. This path is combinational from OutReadyxSI; this is intended.
- S2 update, when Adv2:
  - V2 <= V1, and S2 data loads from S1 when V1.
  - When V2 is held, S2 data is unchanged.
- S1 update, when InReadyxSO:
  - V1 <= InValidxSI, and S1 data loads when InValidxSI.
  - Otherwise S1 holds.
- Data registers do not load on non-valid beats. Bubbles leave old data in place, and this is don't-care downstream.
- BeatCntxDO increments by 1 on every transfer in and wraps from 2^CNT_W-1 to 0.
- Simultaneous transfer in and transfer out in the same cycle is allowed. The pipeline shifts and holds two beats max.
- Reset (any time, including mid-transfer):
  - V1 = V2 = 0, and all S1/S2 data = 0.
  - BeatCntxDO = 0.
  - In-flight beats are discarded.
- Reset values of outputs: ZxDO0 = ZxDO1 = 0, OutValidxSO = 0, BeatCntxDO = 0. InReadyxSO = 1 while RstxBI is low and after reset.

## Timing
- Latency: a beat accepted at edge k appears on ZxDO0/ZxDO1 with OutValidxSO = 1 after edge k+1, i.e. 2 register stages.
- Throughput: 1 beat/cycle with OutReadyxSI held high.
- Backpressure (OutReadyxSI low, both stages full):
  - InReadyxSO = 0.
  - Outputs and S1 hold bit-exact.
  - No beat is lost or duplicated.
- Release: InReadyxSO rises in the same cycle OutReadyxSI rises (combinational). The next edge moves S1 into S2 and accepts the new beat.
- Empty pipeline with InValidxSI low: OutValidxSO falls after the last beat drains. Outputs are otherwise stable.
- Outputs are registered only. No combinational path runs from QxDI*/MaskxDI to ZxDO*.

## Test plan
- Single beat: reset, then Q = 1,2,4,8 and Mask = 5 with OutReadyxSI = 1.
  - Two edges later: ZxDO0 = 6, ZxDO1 = 9, OutValidxSO = 1 for one cycle, BeatCntxDO = 1.
- Streaming: 16 back-to-back beats with random Q/Mask and OutReadyxSI = 1.
  - Outputs appear in order at latency 2.
  - ZxDO0 ^ ZxDO1 equals the XOR of the 4 input shares on every beat.
  - InReadyxSO stays 1. BeatCntxDO = 16.
- Backpressure: stream beats A, B, C; drop OutReadyxSI for 5 cycles after A is output-valid.
  - InReadyxSO goes 0 with A held on the outputs and B in S1.
  - On release: A, B, C emerge in order with no loss or duplication.
- Bubbles: InValidxSI pattern 1,0,1,0.
  - OutValidxSO pattern is 1,0,1,0 delayed 2 cycles.
  - Output data on valid cycles is correct.
- Counter wrap with CNT_W = 4: 17 beats accepted.
  - BeatCntxDO goes 15 -> 0 -> 1.
- Mid-operation reset: assert RstxBI low asynchronously while both stages are full and OutReadyxSI = 0.
  - Immediately: OutValidxSO = 0, ZxDO* = 0, BeatCntxDO = 0, InReadyxSO = 1.
  - After release: the first new beat emerges at latency 2.
